// File: rtl/ascii_time_parser_pkg.sv
`default_nettype none
// ============================================================================
// ascii_time_parser_pkg : ASCII codes, packed time layout and limits
// Rev 1.0
// ============================================================================
package ascii_time_parser_pkg;

  localparam logic [7:0] ASCII_T     = 8'h54;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;

  // Packed time word layout, shared with the time sender
  localparam int TIME_W   = 24;
  localparam int HOUR_MSB = 23;
  localparam int HOUR_LSB = 19;
  localparam int HOUR_W   = 5;
  localparam int MIN_MSB  = 18;
  localparam int MIN_LSB  = 13;
  localparam int MIN_W    = 6;
  localparam int SEC_MSB  = 12;
  localparam int SEC_LSB  = 7;
  localparam int SEC_W    = 6;
  localparam int MSEC_MSB = 6;
  localparam int MSEC_LSB = 0;

  localparam logic [6:0] HOUR_MAX   = 7'd23;
  localparam logic [6:0] MINSEC_MAX = 7'd59;

  typedef enum logic [3:0] {
    S_IDLE, S_H10, S_H1, S_C1, S_M10, S_M1, S_C2, S_S10, S_S1, S_TERM
  } parse_state_t;

  function automatic logic is_terminator(input logic [7:0] b);
    return (b == ASCII_LF) || (b == ASCII_CR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ascii_digit_check.sv
`default_nettype none
// ============================================================================
// ascii_digit_check : classifies a byte as an ASCII decimal digit
// Rev 1.0
// ============================================================================
module ascii_digit_check
  import ascii_time_parser_pkg::*;
(
  input  logic [7:0] byte_in,
  output logic       is_digit,
  output logic [3:0] value
);

  always_comb begin
    is_digit = (byte_in >= ASCII_0) && (byte_in <= ASCII_9);
    value    = is_digit ? byte_in[3:0] : 4'd0;
  end

endmodule
`default_nettype wire

// File: rtl/ascii_time_parser.sv
`default_nettype none
// ============================================================================
// ascii_time_parser : parses "THH:MM:SS<LF|CR>" from the RX byte stream
// Rev 1.0
// ============================================================================
module ascii_time_parser
  import ascii_time_parser_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic [TIME_W-1:0] time_set,
  output logic              set_valid,
  output logic              parse_err
);

  localparam int              CNT_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);

  parse_state_t      state_q, state_d;
  logic [3:0]        tens_q, tens_d;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic [MIN_W-1:0]  min_q, min_d;
  logic [SEC_W-1:0]  sec_q, sec_d;
  logic              range_bad_q, range_bad_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic              set_valid_q, set_valid_d;
  logic              parse_err_q, parse_err_d;

  logic       is_digit;
  logic [3:0] dig_val;
  logic [6:0] field;
  logic       byte_err;

  ascii_digit_check u_digit (
    .byte_in  (rx_data),
    .is_digit (is_digit),
    .value    (dig_val)
  );

  // Full 7-bit value so out-of-range fields are caught before truncation
  assign field = 7'(tens_q) * 7'd10 + 7'(dig_val);

  always_comb begin
    state_d     = state_q;
    tens_d      = tens_q;
    hour_d      = hour_q;
    min_d       = min_q;
    sec_d       = sec_q;
    range_bad_d = range_bad_q;
    time_d      = time_q;
    set_valid_d = 1'b0;
    parse_err_d = 1'b0;
    byte_err    = 1'b0;
    cnt_d       = (state_q == S_IDLE || rx_done) ? '0 : cnt_q + CNT_W'(1);

    if (rx_done && (rx_data == ASCII_T)) begin
      state_d     = S_H10;
      tens_d      = '0;
      hour_d      = '0;
      min_d       = '0;
      sec_d       = '0;
      range_bad_d = 1'b0;
    end else if (rx_done && state_q != S_IDLE) begin
      case (state_q)
        S_H10, S_M10, S_S10: begin
          if (is_digit) begin
            tens_d  = dig_val;
            state_d = (state_q == S_H10) ? S_H1 : (state_q == S_M10) ? S_M1 : S_S1;
          end else byte_err = 1'b1;
        end
        S_H1: begin
          if (is_digit) begin
            hour_d      = field[HOUR_W-1:0];
            range_bad_d = range_bad_q | (field > HOUR_MAX);
            state_d     = S_C1;
          end else byte_err = 1'b1;
        end
        S_M1: begin
          if (is_digit) begin
            min_d       = field[MIN_W-1:0];
            range_bad_d = range_bad_q | (field > MINSEC_MAX);
            state_d     = S_C2;
          end else byte_err = 1'b1;
        end
        S_S1: begin
          if (is_digit) begin
            sec_d       = field[SEC_W-1:0];
            range_bad_d = range_bad_q | (field > MINSEC_MAX);
            state_d     = S_TERM;
          end else byte_err = 1'b1;
        end
        S_C1, S_C2: begin
          if (rx_data == ASCII_COLON) state_d = (state_q == S_C1) ? S_M10 : S_S10;
          else byte_err = 1'b1;
        end
        S_TERM: begin
          if (is_terminator(rx_data)) begin
            state_d = S_IDLE;
            if (range_bad_q) begin
              parse_err_d = 1'b1;
            end else begin
              time_d                    = '0;
              time_d[HOUR_MSB:HOUR_LSB] = hour_q;
              time_d[MIN_MSB:MIN_LSB]   = min_q;
              time_d[SEC_MSB:SEC_LSB]   = sec_q;
              time_d[MSEC_MSB:MSEC_LSB] = '0;
              set_valid_d               = 1'b1;
            end
          end else byte_err = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (!rx_done && state_q != S_IDLE && cnt_q == CNT_LIMIT) begin
      byte_err = 1'b1;
    end

    if (byte_err) begin
      parse_err_d = 1'b1;
      state_d     = S_IDLE;
    end
    if (state_d == S_IDLE) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tens_q      <= '0;
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      range_bad_q <= 1'b0;
      cnt_q       <= '0;
      time_q      <= '0;
      set_valid_q <= 1'b0;
      parse_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tens_q      <= tens_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      range_bad_q <= range_bad_d;
      cnt_q       <= cnt_d;
      time_q      <= time_d;
      set_valid_q <= set_valid_d;
      parse_err_q <= parse_err_d;
    end
  end

  assign time_set  = time_q;
  assign set_valid = set_valid_q;
  assign parse_err = parse_err_q;

endmodule
`default_nettype wire

// File: doc/ascii_time_parser.md
# ascii_time_parser

UART-side receiver that parses an ASCII time-set command (`THH:MM:SS` plus line terminator) from the RX byte stream. It produces a packed 24-bit time word for loading the watch counters. It is the inbound counterpart of the time sender: the packed format is identical, and it sits beside the RX character decoders, fed by the same `rx_data`/`rx_done` pair.

## Interface
- `TIMEOUT_CYC`, 100_000_000: maximum clock cycles allowed between bytes inside a frame (1 s at 100 MHz).
- `clk` input 1: system clock.
- `rst` input 1: reset. One clock; reset is synchronous and active-high.
- `rx_data` input 8: received byte; valid only in the `rx_done` cycle.
- `rx_done` input 1: one-cycle strobe marking a received byte.
- `time_set` output 24: packed time, `[23:19]` hour, `[18:13]` min, `[12:7]` sec, `[6:0]` msec (always 0). Reset 0.
- `set_valid` output 1: one-cycle pulse; `time_set` was just updated. Reset 0.
- `parse_err` output 1: one-cycle pulse; frame aborted. Reset 0.

## Operation
- Frame: `T` (0x54), `H`, `H`, `:` (0x3A), `M`, `M`, `:`, `S`, `S`, then a terminator, LF (0x0A) or CR (0x0D). Digits are 0x30–0x39.
- FSM states: IDLE, H10, H1, C1, M10, M1, C2, S10, S1, TERM. Each state consumes exactly one byte per `rx_done`.
- IDLE: only `T` has effect, moving to H10. All other bytes are ignored silently.
- Expected byte received: advance to the next state.
  - A tens digit is stored as 0–9.
  - On the ones digit, field = tens×10 + ones, stored in a hour (5b), min (6b) or sec (6b) register. Max intermediate value 99 requires 7 bits; truncate only after the range check.
- `T` received in any non-IDLE state: restart at H10 and discard partial fields. This is not an error.
- Any other unexpected byte in a non-IDLE state: pulse `parse_err`, go to IDLE.
- TERM, terminator received:
  - Range check: hour ≤ 23, min ≤ 59, sec ≤ 59.
  - Pass: load `time_set = {hour, min, sec, 7'd0}`, pulse `set_valid`.
  - Fail: pulse `parse_err`; `time_set` is unchanged.
  - Either way, go to IDLE.
- Timeout: the inter-byte counter runs in every non-IDLE state and clears on each `rx_done`. When it reaches `TIMEOUT_CYC`: pulse `parse_err`, go to IDLE. The counter holds 0 in IDLE.
- `set_valid` and `parse_err` are never asserted in the same cycle.
- `time_set` holds its value between valid frames.

## Timing
- All outputs are registered.
- `set_valid` and `parse_err` assert in the cycle after the `rx_done` of the deciding byte, for exactly 1 cycle.
- `time_set` changes in the same cycle `set_valid` is high.
- Timeout `parse_err` asserts 1 cycle after the counter reaches `TIMEOUT_CYC`.
- `rx_done` in the same cycle the counter would hit `TIMEOUT_CYC`: the byte wins, the counter clears, and there is no error.
- Back-to-back `rx_done` on consecutive cycles must be accepted with no loss.
- `rst` high at a clock edge, including mid-frame: state IDLE, counter 0, field registers 0, all outputs 0. The next frame needs a fresh `T`.

## Structure
- Shared package holds:
  - ASCII constants: `T`, `:`, LF, CR, `0`, `9`.
  - Packed time field positions and widths (hour 23:19, min 18:13, sec 12:7, msec 6:0), also used by the sender.
  - Range limits 23 / 59.
- One sub-module, `ascii_digit_check`: combinational; byte in → `is_digit` plus 4-bit value out.
- FSM, field registers and timeout counter live in the top module.

## Test plan
- `T12:34:56\n` → one `set_valid` pulse, `time_set` = 0x645C00, `parse_err` stays 0.
- `T24:00:00\r` → one `parse_err` at the terminator; `time_set` keeps its prior value; no `set_valid`.
- `T1a`, then `:34:56\n` → `parse_err` one cycle after `a`. The remaining bytes are ignored (no further pulses) until the next `T`.
- `T12:T23:59:59\r` → no error at the second `T`; `set_valid`, `time_set` = 0xBF7D80.
- `T12:3`, then no bytes for `TIMEOUT_CYC` cycles (bench parameter 50) → `parse_err` one cycle after the counter reaches 50. A following `T00:00:01\n` → `time_set` = 0x000080.
  - Repeat with `rx_done` landing exactly on the timeout cycle → no error.
- `rst` asserted after `T12:3` → all outputs 0. Then `4:56\n` → ignored. Then `T01:02:03\n` → `time_set` = 0x084180.
